// File: rtl/axil_rq_requester.sv
// axil_rq_requester: AXI-Lite programmed single-DW PCIe MWr/MRd requester.
// The processor loads address/data registers, rings CTRL.START, and the block
// emits one RQ beat; reads then wait for the tag-matched RC completion.
// Ports:
//   clk, rst          - clock; synchronous active-low reset
//   s_axi_*           - AXI-Lite register slave (8-bit byte address, 32-bit data)
//   m_axis_rq_*       - single-beat RQ request stream to the PCIe core
//   s_axis_rc_*       - RC completion stream from the PCIe core (always ready)
module axil_rq_requester #(
  parameter logic [15:0] REQUESTER_ID   = 16'h0000,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   s_axi_awaddr,
  input  logic         s_axi_awvalid,
  output logic         s_axi_awready,
  input  logic [31:0]  s_axi_wdata,
  input  logic [3:0]   s_axi_wstrb,
  input  logic         s_axi_wvalid,
  output logic         s_axi_wready,
  output logic [1:0]   s_axi_bresp,
  output logic         s_axi_bvalid,
  input  logic         s_axi_bready,
  input  logic [7:0]   s_axi_araddr,
  input  logic         s_axi_arvalid,
  output logic         s_axi_arready,
  output logic [31:0]  s_axi_rdata,
  output logic [1:0]   s_axi_rresp,
  output logic         s_axi_rvalid,
  input  logic         s_axi_rready,
  output logic [511:0] m_axis_rq_tdata,
  output logic [63:0]  m_axis_rq_tkeep,
  output logic         m_axis_rq_tlast,
  output logic [136:0] m_axis_rq_tuser,
  output logic         m_axis_rq_tvalid,
  input  logic         m_axis_rq_tready,
  input  logic [511:0] s_axis_rc_tdata,
  input  logic         s_axis_rc_tvalid,
  output logic         s_axis_rc_tready
);

  localparam int unsigned DATA_W = 512;
  localparam int unsigned KEEP_W = 64;
  localparam int unsigned USER_W = 137;

  localparam logic [5:0] REG_ADDR_LO = 6'd0;
  localparam logic [5:0] REG_ADDR_HI = 6'd1;
  localparam logic [5:0] REG_WDATA   = 6'd2;
  localparam logic [5:0] REG_CTRL    = 6'd3;
  localparam logic [5:0] REG_STATUS  = 6'd4;
  localparam logic [5:0] REG_RDATA   = 6'd5;
  localparam logic [5:0] REG_TAG     = 6'd6;

  typedef enum logic [1:0] {IDLE, SEND, WAIT_RC} state_t;

  state_t        state_q, state_d;
  logic [31:0]   addr_lo_q, addr_hi_q, wdata_q, rdata_q, axi_rdata_q;
  logic [7:0]    tag_q;
  logic [15:0]   tmo_cnt_q;
  logic          is_read_q, done_q, err_q;
  logic          bvalid_q, rvalid_q;
  logic [1:0]    bresp_q;

  logic          busy_c, send_c;
  logic          wr_hs_c, wr_prot_c, wr_ok_c, start_c;
  logic          rd_hs_c, status_rd_c;
  logic [5:0]    wr_idx_c;
  logic [31:0]   rd_data_c;
  logic          rc_match_c, rc_ok_c, rc_bad_c, timeout_c, rq_fire_c;
  logic          set_done_c, set_err_c;
  logic [DATA_W-1:0] rq_data_c;
  logic          unused_c;

  // Byte-lane merge for strobed register writes
  function automatic logic [31:0] apply_strb(input logic [31:0] old,
                                             input logic [31:0] din,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = din[8*i +: 8];
    end
    return res;
  endfunction

  assign busy_c   = (state_q != IDLE);
  assign send_c   = (state_q == SEND);

  // AXI-Lite write channel: AW and W accepted together
  assign wr_hs_c       = s_axi_awvalid & s_axi_wvalid & ~bvalid_q;
  assign s_axi_awready = wr_hs_c;
  assign s_axi_wready  = wr_hs_c;
  assign wr_idx_c      = s_axi_awaddr[7:2];
  // Programming registers are locked while a request is in flight
  assign wr_prot_c     = busy_c & (wr_idx_c <= REG_CTRL);
  assign wr_ok_c       = wr_hs_c & ~wr_prot_c;
  assign start_c       = wr_ok_c & (wr_idx_c == REG_CTRL) & s_axi_wstrb[0] & s_axi_wdata[0];
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;

  // AXI-Lite read channel
  assign rd_hs_c       = s_axi_arvalid & ~rvalid_q;
  assign s_axi_arready = ~rvalid_q;
  assign status_rd_c   = rd_hs_c & (s_axi_araddr[7:2] == REG_STATUS);
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = axi_rdata_q;
  assign s_axi_rresp   = 2'b00;

  // Register read mux
  always_comb begin
    rd_data_c = '0;
    case (s_axi_araddr[7:2])
      REG_ADDR_LO: rd_data_c = addr_lo_q;
      REG_ADDR_HI: rd_data_c = addr_hi_q;
      REG_WDATA:   rd_data_c = wdata_q;
      REG_STATUS:  rd_data_c = {29'd0, err_q, done_q, busy_c};
      REG_RDATA:   rd_data_c = rdata_q;
      REG_TAG:     rd_data_c = {24'd0, tag_q};
      default:     rd_data_c = '0;
    endcase
  end

  // tag_q has already advanced past the issued tag once in WAIT_RC
  assign rc_match_c = (state_q == WAIT_RC) & s_axis_rc_tvalid &
                      (s_axis_rc_tdata[71:64] == (tag_q - 8'd1));

  // Next-state and event decode
  always_comb begin
    state_d   = state_q;
    rq_fire_c = 1'b0;
    rc_ok_c   = 1'b0;
    rc_bad_c  = 1'b0;
    timeout_c = 1'b0;
    case (state_q)
      IDLE: if (start_c) state_d = SEND;
      SEND: begin
        if (m_axis_rq_tready) begin
          rq_fire_c = 1'b1;
          state_d   = is_read_q ? WAIT_RC : IDLE;
        end
      end
      WAIT_RC: begin
        // A completion in the timeout cycle takes precedence
        if (rc_match_c) begin
          if ((s_axis_rc_tdata[45:43] == 3'd0) && (s_axis_rc_tdata[15:12] == 4'd0)) rc_ok_c = 1'b1;
          else rc_bad_c = 1'b1;
          state_d = IDLE;
        end else if (tmo_cnt_q == (TIMEOUT_CYCLES - 16'd1)) begin
          timeout_c = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign set_done_c = (rq_fire_c & ~is_read_q) | rc_ok_c | rc_bad_c | timeout_c;
  assign set_err_c  = rc_bad_c | timeout_c;

  // State and register update; a same-cycle set beats a STATUS read clear
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      addr_lo_q   <= '0;
      addr_hi_q   <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      axi_rdata_q <= '0;
      tag_q       <= '0;
      tmo_cnt_q   <= '0;
      is_read_q   <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      bvalid_q    <= 1'b0;
      bresp_q     <= 2'b00;
      rvalid_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (wr_ok_c) begin
        case (wr_idx_c)
          REG_ADDR_LO: addr_lo_q <= apply_strb(addr_lo_q, s_axi_wdata, s_axi_wstrb) & 32'hFFFF_FFFC;
          REG_ADDR_HI: addr_hi_q <= apply_strb(addr_hi_q, s_axi_wdata, s_axi_wstrb);
          REG_WDATA:   wdata_q   <= apply_strb(wdata_q, s_axi_wdata, s_axi_wstrb);
          default: ;
        endcase
      end
      if (start_c) is_read_q <= s_axi_wdata[1];
      if (rq_fire_c) begin
        tag_q     <= tag_q + 8'd1;
        tmo_cnt_q <= '0;
      end else if (state_q == WAIT_RC) begin
        tmo_cnt_q <= tmo_cnt_q + 16'd1;
      end
      if (rc_ok_c) rdata_q <= s_axis_rc_tdata[127:96];
      if (set_done_c) done_q <= 1'b1;
      else if (start_c || status_rd_c) done_q <= 1'b0;
      if (set_err_c) err_q <= 1'b1;
      else if (start_c || status_rd_c) err_q <= 1'b0;
      if (wr_hs_c) begin
        bvalid_q <= 1'b1;
        bresp_q  <= wr_prot_c ? 2'b10 : 2'b00;
      end else if (s_axi_bready) begin
        bvalid_q <= 1'b0;
      end
      if (rd_hs_c) begin
        rvalid_q    <= 1'b1;
        axi_rdata_q <= rd_data_c;
      end else if (s_axi_rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  // RQ descriptor; zero outside SEND so idle outputs stay quiet
  always_comb begin
    rq_data_c = '0;
    if (send_c) begin
      rq_data_c[63:2]   = {addr_hi_q, addr_lo_q[31:2]};
      rq_data_c[74:64]  = 11'd1;
      rq_data_c[78:75]  = is_read_q ? 4'b0000 : 4'b0001;
      rq_data_c[95:80]  = REQUESTER_ID;
      rq_data_c[103:96] = tag_q;
      if (!is_read_q) rq_data_c[159:128] = wdata_q;
    end
  end

  assign m_axis_rq_tdata  = rq_data_c;
  assign m_axis_rq_tkeep  = send_c ? (is_read_q ? KEEP_W'(64'hF) : KEEP_W'(64'h1F)) : '0;
  assign m_axis_rq_tlast  = send_c;
  assign m_axis_rq_tuser  = send_c ? USER_W'(4'hF) : '0;
  assign m_axis_rq_tvalid = send_c;
  assign s_axis_rc_tready = 1'b1;

  assign unused_c = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0], s_axis_rc_tdata[511:128],
                      s_axis_rc_tdata[95:72], s_axis_rc_tdata[63:46], s_axis_rc_tdata[42:16],
                      s_axis_rc_tdata[11:0]};

endmodule

// File: tb/tb_axil_rq_requester.sv
`timescale 1ns/1ps
module tb_axil_rq_requester;

  localparam logic [15:0] RID = 16'hA5C3;
  localparam logic [15:0] TMO = 16'd16;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [7:0]   awaddr = '0;
  logic         awvalid = 1'b0, awready;
  logic [31:0]  wdata = '0;
  logic [3:0]   wstrb = '0;
  logic         wvalid = 1'b0, wready;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready = 1'b1;
  logic [7:0]   araddr = '0;
  logic         arvalid = 1'b0, arready;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rvalid;
  logic         rready = 1'b1;
  logic [511:0] tdata;
  logic [63:0]  tkeep;
  logic         tlast;
  logic [136:0] tuser;
  logic         tvalid;
  logic         tready = 1'b0;
  logic [511:0] rc_tdata = '0;
  logic         rc_tvalid = 1'b0;
  logic         rc_tready;

  always #5 clk = ~clk;

  axil_rq_requester #(.REQUESTER_ID(RID), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .m_axis_rq_tdata(tdata), .m_axis_rq_tkeep(tkeep), .m_axis_rq_tlast(tlast),
    .m_axis_rq_tuser(tuser), .m_axis_rq_tvalid(tvalid), .m_axis_rq_tready(tready),
    .s_axis_rc_tdata(rc_tdata), .s_axis_rc_tvalid(rc_tvalid), .s_axis_rc_tready(rc_tready)
  );

  typedef struct { logic [511:0] data; logic [63:0] keep; } rq_t;
  typedef struct { logic [7:0] addr; logic [31:0] data; } rd_t;

  rq_t        rq_exp[$];
  rd_t        r_exp[$];
  logic [1:0] b_exp[$];

  int checks = 0;
  int failures = 0;

  // Reference model state (register-map view of the block)
  logic [31:0] m_lo, m_hi, m_wd, m_rdata;
  logic [7:0]  m_tag, m_rd_tag;
  logic        m_busy, m_done, m_err, m_is_read, m_waiting;
  rq_t         m_rq;

  task automatic chk(input bit ok, input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    m_lo = '0; m_hi = '0; m_wd = '0; m_rdata = '0;
    m_tag = '0; m_rd_tag = '0;
    m_busy = 0; m_done = 0; m_err = 0; m_is_read = 0; m_waiting = 0;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_read(input logic [7:0] a);
    case (a[7:2])
      6'd0: return m_lo;
      6'd1: return m_hi;
      6'd2: return m_wd;
      6'd4: return {29'd0, m_err, m_done, m_busy};
      6'd5: return m_rdata;
      6'd6: return {24'd0, m_tag};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_start(input logic rd);
    m_is_read = rd; m_busy = 1; m_done = 0; m_err = 0;
    m_rq.data = '0;
    m_rq.data[63:0]    = {m_hi, m_lo};
    m_rq.data[74:64]   = 11'd1;
    m_rq.data[78:75]   = rd ? 4'b0000 : 4'b0001;
    m_rq.data[95:80]   = RID;
    m_rq.data[103:96]  = m_tag;
    if (!rd) m_rq.data[159:128] = m_wd;
    m_rq.keep = rd ? 64'hF : 64'h1F;
    rq_exp.push_back(m_rq);
    m_rd_tag = m_tag;
    m_tag = m_tag + 8'd1;
  endtask

  task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [1:0] resp;
    int idx;
    idx = int'(a[7:2]);
    if (m_busy && idx <= 3) resp = 2'b10;
    else begin
      resp = 2'b00;
      case (idx)
        0: m_lo = merge(m_lo, d, s) & 32'hFFFF_FFFC;
        1: m_hi = merge(m_hi, d, s);
        2: m_wd = merge(m_wd, d, s);
        3: if (s[0] && d[0]) model_start(d[1]);
        default: ;
      endcase
    end
    b_exp.push_back(resp);
    @(posedge clk); #1;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0;
  endtask

  task automatic axi_read(input logic [7:0] a);
    rd_t e;
    e.addr = a;
    e.data = model_read(a);
    if (a[7:2] == 6'd4) begin m_done = 0; m_err = 0; end
    r_exp.push_back(e);
    @(posedge clk); #1;
    araddr = a; arvalid = 1;
    @(posedge clk); #1;
    arvalid = 0;
  endtask

  // Hold tready low for the first beat plus 'stall' cycles, then accept it
  task automatic do_send(input int stall);
    @(negedge clk);
    chk(tvalid === 1'b1 && tdata === m_rq.data, "rq_first", tdata, m_rq.data);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk(tvalid === 1'b1 && tdata === m_rq.data && tkeep === m_rq.keep, "rq_stable", tdata, m_rq.data);
    end
    @(posedge clk); #1 tready = 1;
    @(posedge clk); #1 tready = 0;
    if (m_is_read) m_waiting = 1;
    else begin m_busy = 0; m_done = 1; end
    @(negedge clk);
    chk(tvalid === 1'b0, "rq_drop", tvalid, 0);
  endtask

  task automatic send_rc(input logic [7:0] tg, input logic [2:0] st, input logic [3:0] ec, input logic [31:0] d);
    logic [511:0] t;
    for (int i = 0; i < 16; i++) t[32*i +: 32] = $urandom;
    t[71:64] = tg; t[45:43] = st; t[15:12] = ec; t[127:96] = d;
    @(posedge clk); #1;
    rc_tdata = t; rc_tvalid = 1;
    @(posedge clk); #1;
    rc_tvalid = 0;
    if (m_waiting && tg == m_rd_tag) begin
      m_waiting = 0; m_busy = 0; m_done = 1;
      if (st == 3'd0 && ec == 4'd0) m_rdata = d;
      else m_err = 1;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 0;
    @(posedge clk);
    @(negedge clk);
    chk(tvalid === 1'b0 && bvalid === 1'b0 && rvalid === 1'b0, "rst_outputs", {tvalid, bvalid, rvalid}, 0);
    @(posedge clk); #1 rst = 1;
    model_clear();
    rq_exp.delete();
  endtask

  task automatic model_timeout();
    m_waiting = 0; m_busy = 0; m_done = 1; m_err = 1;
  endtask

  // Scoreboard monitor: pops an expectation for every observed handshake
  logic [1:0] mon_b;
  rd_t        mon_r;
  rq_t        mon_q;
  always @(negedge clk) begin
    if (rst) begin
      if (bvalid) begin
        if (b_exp.size() == 0) chk(1'b0, "b_unexpected", bresp, 0);
        else begin
          mon_b = b_exp.pop_front();
          chk(bresp === mon_b, "bresp", bresp, mon_b);
        end
      end
      if (rvalid) begin
        if (r_exp.size() == 0) chk(1'b0, "r_unexpected", rdata, 0);
        else begin
          mon_r = r_exp.pop_front();
          chk(rdata === mon_r.data && rresp === 2'b00, $sformatf("rdata_at_%0h", mon_r.addr), rdata, mon_r.data);
        end
      end
      if (tvalid && tready) begin
        if (rq_exp.size() == 0) chk(1'b0, "rq_unexpected", tdata, 0);
        else begin
          mon_q = rq_exp.pop_front();
          chk(tdata === mon_q.data, "rq_tdata", tdata, mon_q.data);
          chk(tkeep === mon_q.keep && tlast === 1'b1 && tuser === 137'hF, "rq_side", {tkeep, tlast, tuser}, {mon_q.keep, 1'b1, 137'hF});
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  logic [2:0]  st;
  logic [3:0]  ec;
  logic        rd;
  int          kind, nwrong;

  initial begin
    model_clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk(tvalid === 0 && tdata === '0 && tkeep === '0 && tlast === 0 && tuser === '0, "reset_rq", {tvalid, tlast, tkeep}, 0);
    chk(bvalid === 0 && rvalid === 0 && awready === 0 && wready === 0 && rc_tready === 1, "reset_axi",
        {bvalid, rvalid, awready, wready, rc_tready}, 5'b00001);
    #1 rst = 1;
    for (int a = 0; a < 7; a++) axi_read(8'(a * 4));

    // Directed MWr with a 3-cycle stall
    axi_write(8'h00, 32'h0000_1000, 4'hF);
    axi_write(8'h04, 32'h0, 4'hF);
    axi_write(8'h08, 32'hDEAD_BEEF, 4'hF);
    axi_write(8'h0C, 32'h1, 4'hF);
    @(negedge clk);
    chk(tdata[63:2] === 62'h400 && tdata[78:75] === 4'b0001 && tdata[159:128] === 32'hDEADBEEF && tkeep === 64'h1F,
        "mwr_fields", tdata[159:0], {32'hDEADBEEF, 50'd0, 4'b0001, 12'd1, 62'h400, 2'b00});
    do_send(3);
    axi_read(8'h10);
    axi_read(8'h18);
    axi_read(8'h10);

    // Directed MRd
    axi_write(8'h0C, 32'h3, 4'hF);
    do_send(0);
    axi_read(8'h10);
    send_rc(m_rd_tag, 3'd0, 4'd0, 32'hCAFE_F00D);
    axi_read(8'h14);
    axi_read(8'h10);
    axi_read(8'h10);

    // Wrong-tag beats ignored
    axi_write(8'h0C, 32'h3, 4'hF);
    do_send(1);
    send_rc(m_rd_tag + 8'd5, 3'd0, 4'd0, 32'h1111_1111);
    send_rc(m_rd_tag + 8'd7, 3'd0, 4'd0, 32'h2222_2222);
    axi_read(8'h10);
    send_rc(m_rd_tag, 3'd0, 4'd0, 32'h3333_3333);
    axi_read(8'h14);
    axi_read(8'h10);

    // Completion status error, then completion error code
    axi_write(8'h0C, 32'h3, 4'hF);
    do_send(0);
    send_rc(m_rd_tag, 3'b001, 4'd0, 32'h4444_4444);
    axi_read(8'h10);
    axi_read(8'h14);
    axi_write(8'h0C, 32'h3, 4'hF);
    do_send(0);
    send_rc(m_rd_tag, 3'd0, 4'h2, 32'h5555_5555);
    axi_read(8'h10);

    // Timeout: still busy when read on the timeout edge, DONE wins that edge
    axi_write(8'h0C, 32'h3, 4'hF);
    do_send(0);
    repeat (14) @(posedge clk);
    axi_read(8'h10);
    model_timeout();
    axi_read(8'h10);
    axi_read(8'h10);
    // Timeout visible one edge later
    axi_write(8'h0C, 32'h3, 4'hF);
    do_send(0);
    repeat (15) @(posedge clk);
    model_timeout();
    axi_read(8'h10);
    // Completion arriving in the timeout cycle wins
    axi_write(8'h0C, 32'h3, 4'hF);
    do_send(0);
    repeat (14) @(posedge clk);
    send_rc(m_rd_tag, 3'd0, 4'd0, 32'h6666_6666);
    axi_read(8'h10);
    axi_read(8'h14);

    // Busy protection
    axi_write(8'h08, 32'h7777_7777, 4'hF);
    axi_write(8'h0C, 32'h1, 4'hF);
    axi_write(8'h0C, 32'h1, 4'hF);
    axi_write(8'h00, 32'h0000_ABC0, 4'hF);
    axi_write(8'h08, 32'h0, 4'hF);
    axi_write(8'h1C, 32'hFFFF_FFFF, 4'hF);
    axi_read(8'h10);
    do_send(0);
    repeat (3) @(negedge clk);
    chk(tvalid === 1'b0, "no_second_rq", tvalid, 0);
    axi_read(8'h00);
    axi_read(8'h10);

    // Strobes, forced address LSBs, unmapped and write-only offsets
    axi_write(8'h00, 32'h1234_5677, 4'b0101);
    axi_write(8'h04, 32'h89AB_CDEF, 4'b1010);
    axi_write(8'h20, 32'hFFFF_FFFF, 4'hF);
    axi_read(8'h00);
    axi_read(8'h04);
    axi_read(8'h0C);
    axi_read(8'h20);

    // Randomized transactions
    for (int it = 0; it < 40; it++) begin
      rd = 1'($urandom_range(0, 1));
      axi_write(8'h00, $urandom, 4'hF);
      axi_write(8'h04, (it % 3 == 0) ? 32'd0 : $urandom, 4'hF);
      axi_write(8'h08, $urandom, 4'($urandom_range(1, 15)));
      axi_write(8'h0C, {30'd0, rd, 1'b1}, 4'hF);
      do_send($urandom_range(0, 3));
      if (rd) begin
        nwrong = $urandom_range(0, 2);
        for (int j = 0; j < nwrong; j++) send_rc(m_rd_tag + 8'(j + 1), 3'd0, 4'd0, $urandom);
        kind = $urandom_range(0, 3);
        st = (kind == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
        ec = (kind == 1) ? 4'($urandom_range(1, 15)) : 4'd0;
        send_rc(m_rd_tag, st, ec, $urandom);
      end
      axi_read(8'h10);
      axi_read(8'h14);
      axi_read(8'h18);
    end

    // Reset while SEND is pending
    axi_write(8'h0C, 32'h1, 4'hF);
    do_reset();
    // Reset while waiting for a completion; the stale completion is dropped
    axi_write(8'h08, 32'h0, 4'hF);
    axi_write(8'h0C, 32'h3, 4'hF);
    axi_write(8'h0C, 32'h3, 4'hF);
    do_send(0);
    st = 3'd0;
    begin
      logic [7:0] old_tag;
      old_tag = m_rd_tag;
      do_reset();
      send_rc(old_tag, 3'd0, 4'd0, 32'h8888_8888);
    end
    axi_read(8'h10);
    axi_read(8'h14);
    axi_read(8'h18);

    // Tag wrap: 256 MWr requests then the 257th carries tag 0
    for (int i = 0; i < 256; i++) begin
      if (i % 16 == 0) axi_write(8'h08, $urandom, 4'hF);
      axi_write(8'h0C, 32'h1, 4'hF);
      do_send(0);
    end
    axi_read(8'h18);
    axi_write(8'h0C, 32'h1, 4'hF);
    @(negedge clk);
    chk(tdata[103:96] === 8'h00, "tag_wrap", tdata[103:96], 0);
    do_send(0);
    axi_read(8'h18);
    axi_read(8'h10);

    repeat (5) @(negedge clk);
    chk(b_exp.size() == 0 && r_exp.size() == 0 && rq_exp.size() == 0, "drain",
        {b_exp.size(), r_exp.size(), rq_exp.size()}, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
